// File: rtl/difftest_monitor_pkg.sv
// Shared encodings for the difftest progress monitor: FSM states, result codes,
// fault reasons and the exit word that signals a clean exit.
// No logic, no latency, no flow control.
package difftest_monitor_pkg;

    // FSM state encoding (kept as plain constants for legacy tooling)
    localparam logic [1:0] ST_WARMUP = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic [1:0] ST_FAIL   = 2'd3;

    // simv_result codes seen by the testbench top
    localparam logic [7:0] RESULT_RUNNING  = 8'd0;
    localparam logic [7:0] RESULT_GOODTRAP = 8'd1;
    localparam logic [7:0] RESULT_EXCEED   = 8'd2;
    localparam logic [7:0] RESULT_FAIL     = 8'd3;
    localparam logic [7:0] RESULT_WARMUP   = 8'd4;

    typedef enum logic [1:0] {
        REASON_NONE  = 2'd0,
        REASON_ABORT = 2'd1,
        REASON_STUCK = 2'd2
    } fail_reason_t;

    localparam logic [63:0] EXIT_GOOD = 64'hFFFF_FFFF_FFFF_FFFF;

    // WARMUP and RUN are the only states in which anything advances
    function automatic logic state_is_active(input logic [1:0] st);
        return (st == ST_WARMUP) || (st == ST_RUN);
    endfunction

endpackage

// File: rtl/difftest_core_watch.sv
// Per-core watcher: decodes the exit word, keeps the sticky good flag and the stuck timer.
// Latency: good/abort are combinational from exit_code; stuck comes from the registered timer.
// Backpressure: none; the core is observed, never stalled.
//
// Ports:
//   clock, reset    clock and asynchronous active-high reset
//   active          monitor is in WARMUP or RUN; state only advances while set
//   step            this core's commit count for the current cycle
//   exit_code       this core's exit word (all-ones good, 0 running, other abort)
//   good            sticky good flag OR a good exit seen this cycle
//   abort           exit word is an abort code this cycle
//   stuck           timer has reached STUCK_LIMIT (never when STUCK_LIMIT is 0)
module difftest_core_watch
    import difftest_monitor_pkg::*;
#(
    parameter int              STEP_WIDTH  = 8,
    parameter int              TIMER_WIDTH = 32,
    parameter longint unsigned STUCK_LIMIT = 5000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  active,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [63:0]           exit_code,
    output logic                  good,
    output logic                  abort,
    output logic                  stuck
);

    logic                   good_flag;
    logic [TIMER_WIDTH-1:0] timer;
    logic                   exit_good;
    logic                   exit_running;

    assign exit_good    = (exit_code == EXIT_GOOD);
    assign exit_running = (exit_code == 64'd0);
    assign abort        = !exit_good && !exit_running;
    assign good         = good_flag || exit_good;

    // The timer is zero whenever the good flag is set, so a core that has
    // exited cleanly can sit idle indefinitely without tripping the check.
    assign stuck = (STUCK_LIMIT != 0) && (64'(timer) >= STUCK_LIMIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            good_flag <= 1'b0;
            timer     <= '0;
        end else if (active) begin
            if (exit_good) begin
                good_flag <= 1'b1;
            end
            // Clearing on the exit cycle itself keeps timer at 0 from the
            // same edge that raises good_flag.
            if (good || (step != '0)) begin
                timer <= '0;
            end else if (timer != '1) begin
                timer <= timer + TIMER_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/difftest_progress_monitor.sv
// Multi-core progress/exit monitor: warmup, max-cycle, stuck and exit checks -> simv_result.
// Latency: all outputs registered; a condition seen in cycle N shows up after edge N.
// Backpressure: none; purely observes commit counts and exit words.
//
// Ports:
//   clock, reset    clock and asynchronous active-high reset
//   step            per-core commit counts, core i at [i*STEP_WIDTH +: STEP_WIDTH]
//   exit_code       per-core 64-bit exit words, core i at [i*64 +: 64]
//   simv_result     0 running, 1 goodtrap, 2 exceed, 3 fail, 4 warmup done (one cycle)
//   perf_clean      one-cycle pulse when warmup ends
//   perf_dump       one-cycle pulse on entry to DONE or FAIL
//   fail_core       index of the faulting core (held)
//   fail_reason     0 none, 1 abort, 2 stuck (held)
//   abort_code      exit word of the faulting core (held)
//   cycle_count     active cycles since reset release
//   instr_count     total committed instructions
module difftest_progress_monitor
    import difftest_monitor_pkg::*;
#(
    parameter int              NUM_CORES     = 2,
    parameter int              STEP_WIDTH    = 8,
    parameter int              CNT_WIDTH     = 64,
    parameter int              TIMER_WIDTH   = 32,
    parameter longint unsigned STUCK_LIMIT   = 5000,
    parameter longint unsigned MAX_CYCLES    = 0,
    parameter longint unsigned WARMUP_INSTRS = 0
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_CORES*STEP_WIDTH-1:0] step,
    input  logic [NUM_CORES*64-1:0]         exit_code,
    output logic [7:0]                      simv_result,
    output logic                            perf_clean,
    output logic                            perf_dump,
    output logic [$clog2(NUM_CORES):0]      fail_core,
    output logic [1:0]                      fail_reason,
    output logic [63:0]                     abort_code,
    output logic [CNT_WIDTH-1:0]            cycle_count,
    output logic [CNT_WIDTH-1:0]            instr_count
);

    localparam int IDX_W = $clog2(NUM_CORES) + 1;
    localparam int SUM_W = STEP_WIDTH + $clog2(NUM_CORES) + 1;
    localparam logic [CNT_WIDTH-1:0] WARMUP_LIM = CNT_WIDTH'(WARMUP_INSTRS);
    localparam logic [CNT_WIDTH-1:0] MAX_LIM    = CNT_WIDTH'(MAX_CYCLES);
    localparam logic [1:0] ST_INIT = (WARMUP_INSTRS != 0) ? ST_WARMUP : ST_RUN;

    logic [1:0]           state;
    logic                 active;
    logic [NUM_CORES-1:0] good;
    logic [NUM_CORES-1:0] abort;
    logic [NUM_CORES-1:0] stuck;

    assign active = state_is_active(state);

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        difftest_core_watch #(
            .STEP_WIDTH  (STEP_WIDTH),
            .TIMER_WIDTH (TIMER_WIDTH),
            .STUCK_LIMIT (STUCK_LIMIT)
        ) u_watch (
            .clock     (clock),
            .reset     (reset),
            .active    (active),
            .step      (step[i*STEP_WIDTH +: STEP_WIDTH]),
            .exit_code (exit_code[i*64 +: 64]),
            .good      (good[i]),
            .abort     (abort[i]),
            .stuck     (stuck[i])
        );
    end

    // Step sum and lowest-index selection for each fault class. Scanning from
    // the top index down lets the lowest faulting core overwrite last.
    logic [SUM_W-1:0] step_sum;
    logic [IDX_W-1:0] abort_idx;
    logic [IDX_W-1:0] stuck_idx;
    logic [63:0]      abort_word;
    logic [63:0]      stuck_word;

    always_comb begin
        step_sum   = '0;
        abort_idx  = '0;
        stuck_idx  = '0;
        abort_word = '0;
        stuck_word = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            step_sum = step_sum + SUM_W'(step[i*STEP_WIDTH +: STEP_WIDTH]);
            if (abort[i]) begin
                abort_idx  = IDX_W'(i);
                abort_word = exit_code[i*64 +: 64];
            end
            if (stuck[i]) begin
                stuck_idx  = IDX_W'(i);
                stuck_word = exit_code[i*64 +: 64];
            end
        end
    end

    logic                 any_abort;
    logic                 any_stuck;
    logic                 max_hit;
    logic                 all_good;
    logic                 warm_done;
    logic [CNT_WIDTH-1:0] instr_next;

    assign any_abort  = |abort;
    assign any_stuck  = |stuck;
    assign max_hit    = (MAX_CYCLES != 0) && (cycle_count >= MAX_LIM);
    assign all_good   = &good;
    // instr_count lags by a cycle, so the warmup test includes this cycle's steps
    assign instr_next = instr_count + CNT_WIDTH'(step_sum);
    assign warm_done  = (instr_next >= WARMUP_LIM);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_INIT;
            simv_result <= RESULT_RUNNING;
            perf_clean  <= 1'b0;
            perf_dump   <= 1'b0;
            fail_core   <= '0;
            fail_reason <= REASON_NONE;
            abort_code  <= '0;
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            perf_clean <= 1'b0;
            perf_dump  <= 1'b0;
            if (active) begin
                cycle_count <= cycle_count + CNT_WIDTH'(1);
                instr_count <= instr_next;
                // Priority: abort > stuck > max-cycle > all-good > warmup end
                if (any_abort || any_stuck) begin
                    state       <= ST_FAIL;
                    simv_result <= RESULT_FAIL;
                    perf_dump   <= 1'b1;
                    fail_core   <= any_abort ? abort_idx : stuck_idx;
                    fail_reason <= any_abort ? REASON_ABORT : REASON_STUCK;
                    abort_code  <= any_abort ? abort_word : stuck_word;
                end else if (max_hit) begin
                    state       <= ST_DONE;
                    simv_result <= RESULT_EXCEED;
                    perf_dump   <= 1'b1;
                end else if (all_good) begin
                    state       <= ST_DONE;
                    simv_result <= RESULT_GOODTRAP;
                    perf_dump   <= 1'b1;
                end else if ((state == ST_WARMUP) && warm_done) begin
                    state       <= ST_RUN;
                    simv_result <= RESULT_WARMUP;
                    perf_clean  <= 1'b1;
                end else begin
                    simv_result <= RESULT_RUNNING;
                end
            end
        end
    end

endmodule

// File: tb/tb_difftest_progress_monitor.sv
`timescale 1ns/1ps
module tb_difftest_progress_monitor;

    localparam int              NC    = 2;
    localparam int              SW    = 8;
    localparam int              CW    = 64;
    localparam longint unsigned LIMIT = 10;
    localparam longint unsigned MAXC  = 200;
    localparam longint unsigned WARM  = 100;
    localparam logic [63:0]     ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic             clock = 1'b0;
    logic             reset;
    logic [NC*SW-1:0] step;
    logic [NC*64-1:0] exit_code;
    logic [7:0]       simv_result;
    logic             perf_clean;
    logic             perf_dump;
    logic [1:0]       fail_core;
    logic [1:0]       fail_reason;
    logic [63:0]      abort_code;
    logic [CW-1:0]    cycle_count;
    logic [CW-1:0]    instr_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    difftest_progress_monitor #(
        .NUM_CORES     (NC),
        .STEP_WIDTH    (SW),
        .CNT_WIDTH     (CW),
        .TIMER_WIDTH   (32),
        .STUCK_LIMIT   (LIMIT),
        .MAX_CYCLES    (MAXC),
        .WARMUP_INSTRS (WARM)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .step        (step),
        .exit_code   (exit_code),
        .simv_result (simv_result),
        .perf_clean  (perf_clean),
        .perf_dump   (perf_dump),
        .fail_core   (fail_core),
        .fail_reason (fail_reason),
        .abort_code  (abort_code),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    // One post-warmup cycle: inputs and the outputs expected after that edge
    typedef struct {
        logic [7:0]  s0;
        logic [7:0]  s1;
        logic [63:0] e0;
        logic [63:0] e1;
        logic [7:0]  res;
        logic        dump;
        logic [1:0]  core;
        logic [1:0]  reason;
        logic [63:0] code;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic [7:0] s0, input logic [7:0] s1,
                          input logic [63:0] e0, input logic [63:0] e1);
        step      = {s1, s0};
        exit_code = {e1, e0};
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        step      = 'x;
        exit_code = 'x;
        repeat (2) @(posedge clock);
        #1;
        set_in(8'd0, 8'd0, 64'd0, 64'd0);
        reset = 1'b0;
    endtask

    // 3+3 steps per cycle: warmup total reaches 102 on edge 17
    task automatic warmup();
        set_in(8'd3, 8'd3, 64'd0, 64'd0);
        repeat (17) tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".res"},    64'(simv_result), 64'd0);
        check({tag, ".clean"},  64'(perf_clean),  64'd0);
        check({tag, ".dump"},   64'(perf_dump),   64'd0);
        check({tag, ".core"},   64'(fail_core),   64'd0);
        check({tag, ".reason"}, 64'(fail_reason), 64'd0);
        check({tag, ".code"},   abort_code,       64'd0);
        check({tag, ".cyc"},    cycle_count,      64'd0);
        check({tag, ".instr"},  instr_count,      64'd0);
    endtask

    // Reference model: stuck is derived from the last cycle each core was
    // busy (stepped or already good), not from a running timer.
    task automatic run_random(input int ncyc, input int pzero);
        int          phase;
        longint      mcyc;
        logic [63:0] minstr;
        bit          mgood [NC];
        longint      last_busy [NC];
        logic [7:0]  s [NC];
        logic [63:0] e [NC];
        logic [7:0]  e_res;
        bit          e_clean, e_dump;
        logic [1:0]  e_core, e_reason;
        logic [63:0] e_code;
        do_reset();
        phase = (WARM != 0) ? 0 : 1;
        mcyc = 0; minstr = 0;
        e_res = 0; e_core = 0; e_reason = 0; e_code = 0;
        for (int i = 0; i < NC; i++) begin
            mgood[i] = 0;
            last_busy[i] = -1;
        end
        for (int n = 0; n < ncyc; n++) begin
            logic [63:0] sum;
            int          fcore;
            int          r;
            bit          allg;
            sum = 0;
            for (int i = 0; i < NC; i++) begin
                s[i] = ($urandom_range(99) < pzero) ? 8'd0 : 8'($urandom_range(255, 1));
                r = $urandom_range(999);
                e[i] = (r < 4) ? ONES : (r < 6) ? {$urandom, $urandom} : 64'd0;
                step[i*SW +: SW] = s[i];
                exit_code[i*64 +: 64] = e[i];
                sum = sum + 64'(s[i]);
            end
            e_clean = 0;
            e_dump  = 0;
            if (phase < 2) begin
                fcore = -1;
                for (int i = 0; i < NC; i++)
                    if (fcore < 0 && e[i] != 0 && e[i] != ONES) begin
                        fcore = i; e_reason = 2'd1;
                    end
                for (int i = 0; i < NC; i++)
                    if (fcore < 0 && (mcyc - 1 - last_busy[i]) >= longint'(LIMIT)) begin
                        fcore = i; e_reason = 2'd2;
                    end
                allg = 1;
                for (int i = 0; i < NC; i++)
                    if (!(mgood[i] || e[i] == ONES)) allg = 0;
                if (fcore >= 0) begin
                    phase = 3; e_res = 8'd3; e_dump = 1;
                    e_core = 2'(fcore); e_code = e[fcore];
                end else if (mcyc >= longint'(MAXC)) begin
                    phase = 2; e_res = 8'd2; e_dump = 1;
                end else if (allg) begin
                    phase = 2; e_res = 8'd1; e_dump = 1;
                end else if (phase == 0 && (minstr + sum) >= WARM) begin
                    phase = 1; e_res = 8'd4; e_clean = 1;
                end else begin
                    e_res = 8'd0;
                end
                for (int i = 0; i < NC; i++) begin
                    if (e[i] == ONES || mgood[i] || s[i] != 0) last_busy[i] = mcyc;
                    if (e[i] == ONES) mgood[i] = 1;
                end
                mcyc++;
                minstr = minstr + sum;
            end
            tick();
            check("rnd.res",    64'(simv_result), 64'(e_res));
            check("rnd.clean",  64'(perf_clean),  64'(e_clean));
            check("rnd.dump",   64'(perf_dump),   64'(e_dump));
            check("rnd.core",   64'(fail_core),   64'(e_core));
            check("rnd.reason", 64'(fail_reason), 64'(e_reason));
            check("rnd.code",   abort_code,       e_code);
            check("rnd.cyc",    cycle_count,      64'(mcyc));
            check("rnd.instr",  instr_count,      minstr);
        end
    endtask

    initial begin
        //           s0     s1     e0        e1        res   dump  core  reason code
        tbl[0] = '{8'd1, 8'd1, 64'h2A,   64'd0,    8'd3, 1'b1, 2'd0, 2'd1, 64'h2A};
        tbl[1] = '{8'd1, 8'd1, ONES,     64'h55,   8'd3, 1'b1, 2'd1, 2'd1, 64'h55};
        tbl[2] = '{8'd0, 8'd0, ONES,     ONES,     8'd1, 1'b1, 2'd0, 2'd0, 64'd0};
        tbl[3] = '{8'd2, 8'd2, 64'h7,    64'h9,    8'd3, 1'b1, 2'd0, 2'd1, 64'h7};
        tbl[4] = '{8'd1, 8'd1, 64'd0,    64'd0,    8'd0, 1'b0, 2'd0, 2'd0, 64'd0};
        tbl[5] = '{8'd3, 8'd3, 64'd0,    ONES,     8'd0, 1'b0, 2'd0, 2'd0, 64'd0};

        // Reset state with X inputs, then the warmup pulse
        do_reset();
        check_zero("reset");
        set_in(8'd3, 8'd3, 64'd0, 64'd0);
        repeat (16) tick();
        check("wu16.res",   64'(simv_result), 64'd0);
        check("wu16.clean", 64'(perf_clean),  64'd0);
        check("wu16.instr", instr_count,      64'd96);
        tick();
        check("wu17.res",   64'(simv_result), 64'd4);
        check("wu17.clean", 64'(perf_clean),  64'd1);
        check("wu17.instr", instr_count,      64'd102);
        check("wu17.cyc",   cycle_count,      64'd17);
        tick();
        check("wu18.res",   64'(simv_result), 64'd0);
        check("wu18.clean", 64'(perf_clean),  64'd0);

        // Single-cycle exit decode / priority vectors
        for (int k = 0; k < 6; k++) begin
            do_reset();
            warmup();
            set_in(tbl[k].s0, tbl[k].s1, tbl[k].e0, tbl[k].e1);
            tick();
            check($sformatf("vec%0d.res", k),    64'(simv_result), 64'(tbl[k].res));
            check($sformatf("vec%0d.dump", k),   64'(perf_dump),   64'(tbl[k].dump));
            check($sformatf("vec%0d.core", k),   64'(fail_core),   64'(tbl[k].core));
            check($sformatf("vec%0d.reason", k), 64'(fail_reason), 64'(tbl[k].reason));
            check($sformatf("vec%0d.code", k),   abort_code,       tbl[k].code);
        end

        // Stuck: core0 idle from edge 18, timer reaches 10 after edge 27
        do_reset();
        warmup();
        set_in(8'd0, 8'd1, 64'd0, 64'd0);
        repeat (10) tick();
        check("stuck.pre", 64'(simv_result), 64'd0);
        tick();
        check("stuck.res",    64'(simv_result), 64'd3);
        check("stuck.dump",   64'(perf_dump),   64'd1);
        check("stuck.core",   64'(fail_core),   64'd0);
        check("stuck.reason", 64'(fail_reason), 64'd2);
        check("stuck.cyc",    cycle_count,      64'd28);
        repeat (3) tick();
        check("stuck.cyc_hold",  cycle_count,      64'd28);
        check("stuck.dump_off",  64'(perf_dump),   64'd0);
        check("stuck.res_hold",  64'(simv_result), 64'd3);

        // Abort on core1 beats stuck on core0 in the same cycle
        do_reset();
        warmup();
        set_in(8'd0, 8'd1, 64'd0, 64'd0);
        repeat (10) tick();
        set_in(8'd0, 8'd1, 64'd0, 64'h2A);
        tick();
        check("abst.res",    64'(simv_result), 64'd3);
        check("abst.core",   64'(fail_core),   64'd1);
        check("abst.reason", 64'(fail_reason), 64'd1);
        check("abst.code",   abort_code,       64'h2A);

        // Good exits: core0 good then idle well past the stuck limit, core1 later
        do_reset();
        warmup();
        set_in(8'd0, 8'd1, ONES, 64'd0);
        tick();
        set_in(8'd0, 8'd1, 64'd0, 64'd0);
        repeat (20) tick();
        check("good.pre", 64'(simv_result), 64'd0);
        set_in(8'd0, 8'd1, 64'd0, ONES);
        tick();
        check("good.res",  64'(simv_result), 64'd1);
        check("good.dump", 64'(perf_dump),   64'd1);
        tick();
        check("good.res_hold", 64'(simv_result), 64'd1);
        check("good.dump_off", 64'(perf_dump),   64'd0);

        // Max cycles: DONE/exceed on edge 201
        do_reset();
        warmup();
        set_in(8'd1, 8'd1, 64'd0, 64'd0);
        repeat (183) tick();
        check("max.pre_res", 64'(simv_result), 64'd0);
        check("max.pre_cyc", cycle_count,      64'd200);
        tick();
        check("max.res",   64'(simv_result), 64'd2);
        check("max.dump",  64'(perf_dump),   64'd1);
        check("max.cyc",   cycle_count,      64'd201);
        check("max.instr", instr_count,      64'd470);
        repeat (3) tick();
        check("max.dump_off",   64'(perf_dump),   64'd0);
        check("max.res_hold",   64'(simv_result), 64'd2);
        check("max.instr_hold", instr_count,      64'd470);
        check("max.cyc_hold",   cycle_count,      64'd201);

        // Asynchronous reset mid-run clears outputs and the sticky good flag
        do_reset();
        warmup();
        set_in(8'd3, 8'd3, ONES, 64'd0);
        tick();
        set_in(8'd3, 8'd3, 64'd0, 64'd0);
        repeat (12) tick();
        #2;
        reset = 1'b1;
        #1;
        check_zero("arst");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        warmup();
        check("arst.rewarm", 64'(perf_clean), 64'd1);
        set_in(8'd3, 8'd3, 64'd0, ONES);
        tick();
        check("arst.flag_clr", 64'(simv_result), 64'd0);

        // Randomized runs against the reference model
        for (int r = 0; r < 24; r++) begin
            int pz;
            pz = (r % 3 == 0) ? 5 : (r % 3 == 1) ? 50 : 85;
            run_random(230, pz);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
